// File: rtl/stream_stim_pkg.sv
// Shared types and helpers for the stream stimulus/checker harness.
package stream_stim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned ERR_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/stream_stim_checker_if.sv
// Bus bundle between the stimulus/checker harness and whatever drives it.
interface stream_stim_checker_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int ADDR_W = 10
);
  import stream_stim_pkg::*;

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_stim;
  logic [OUT_W-1:0]  load_exp;
  logic [ADDR_W:0]   num_samples;
  logic              start;
  logic              stop;
  logic [DATA_W-1:0] stim_data;
  logic              clk_enable;
  logic [OUT_W-1:0]  dut_out;
  logic              busy;
  logic              snk_done;
  logic              test_failure;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W:0]   first_err_idx;

  modport master (
    output load_we, load_addr, load_stim, load_exp, num_samples, start, stop, dut_out,
    input  stim_data, clk_enable, busy, snk_done, test_failure, err_count, first_err_idx
  );

  modport slave (
    input  load_we, load_addr, load_stim, load_exp, num_samples, start, stop, dut_out,
    output stim_data, clk_enable, busy, snk_done, test_failure, err_count, first_err_idx
  );

endinterface

// File: rtl/stim_exp_ram.sv
// Stimulus and expected-value tables sharing one write port and one
// synchronous read port (read data valid the cycle after the address).
module stim_exp_ram #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wstim,
  input  logic [OUT_W-1:0]  wexp,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rstim,
  output logic [OUT_W-1:0]  rexp
);

  logic [DATA_W-1:0] stim_mem [DEPTH];
  logic [OUT_W-1:0]  exp_mem  [DEPTH];

  // Table load: both words land at the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      stim_mem[waddr] <= wstim;
      exp_mem[waddr]  <= wexp;
    end
  end

  // Registered read of both tables.
  always_ff @(posedge clk) begin
    rstim <= stim_mem[raddr];
    rexp  <= exp_mem[raddr];
  end

endmodule

// File: rtl/stream_stim_checker.sv
// Plays a preloaded stimulus table into a clock-enabled DUT and checks the
// DUT output, DUT_LATENCY enabled cycles later, against an expected table.
module stream_stim_checker
  import stream_stim_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OUT_W       = 16,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int DUT_LATENCY = 4,
  parameter int TOL         = 0,
  parameter int HOLD_CYCLES = 2,
  parameter int LOOP_EN     = 0
) (
  input logic                  clk,
  input logic                  reset,
  stream_stim_checker_if.slave bus
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DC_W = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DUT_LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_N    = (ADDR_W+1)'(DEPTH);
  localparam int CW = (OUT_W + 1 > 32) ? OUT_W + 1 : 32;
  localparam logic [CW-1:0] TOL_U = CW'(TOL);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q, n_clamp;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [DC_W-1:0]   drain_q, drain_d;
  logic              stop_q, stop_d;
  logic              start_run;
  logic              last_sample;

  logic              clk_en;
  logic              busy;
  logic              snk_done;
  logic [DATA_W-1:0] stim_out;

  logic [DATA_W-1:0] ram_stim;
  logic [OUT_W-1:0]  ram_exp;

  logic              vld_q  [DUT_LATENCY];
  logic [ADDR_W-1:0] pidx_q [DUT_LATENCY];
  logic [OUT_W-1:0]  pexp_q [DUT_LATENCY];

  logic                cmp_valid;
  logic [ADDR_W-1:0]   cmp_idx;
  logic [OUT_W-1:0]    cmp_exp;
  logic signed [OUT_W:0] diff;
  logic [OUT_W:0]      mag;
  logic                mismatch;

  logic [ERR_W-1:0]  err_q;
  logic              fail_q;
  logic [ADDR_W:0]   first_q;

  assign n_clamp     = (bus.num_samples > DEPTH_N) ? DEPTH_N : bus.num_samples;
  assign last_sample = ({1'b0, idx_q} == (n_q - (ADDR_W+1)'(1)));

  // FSM state and sequencing counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      drain_q <= '0;
      stop_q  <= 1'b0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      stop_q  <= stop_d;
      if (start_run) n_q <= n_clamp;
    end
  end

  // Next-state, counter updates and Moore outputs. idx_d doubles as the
  // RAM read address so table word k is on the RAM output in the cycle
  // the FSM presents index k.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    drain_d   = drain_q;
    stop_d    = stop_q;
    start_run = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          start_run = 1'b1;
          idx_d     = '0;
          hold_d    = '0;
          drain_d   = '0;
          stop_d    = 1'b0;
          if (n_clamp == '0)          state_d = DONE;
          else if (HOLD_CYCLES == 0)  state_d = RUN;
          else                        state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
        else                     hold_d  = hold_q + HC_W'(1);
      end
      RUN: begin
        if ((LOOP_EN != 0) && bus.stop) stop_d = 1'b1;
        if (last_sample) begin
          idx_d = '0;
          if ((LOOP_EN == 0) || stop_q || bus.stop) state_d = DRAIN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + DC_W'(1);
      end
      default: state_d = IDLE;
    endcase

    clk_en   = (state_q == RUN) || (state_q == DRAIN);
    busy     = (state_q == HOLD) || (state_q == RUN) || (state_q == DRAIN);
    snk_done = (state_q == DONE);
    stim_out = (state_q == RUN) ? ram_stim : '0;
  end

  stim_exp_ram #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (bus.load_we && !busy),
    .waddr (bus.load_addr),
    .wstim (bus.load_stim),
    .wexp  (bus.load_exp),
    .raddr (idx_d),
    .rstim (ram_stim),
    .rexp  (ram_exp)
  );

  // Compare-valid tokens; flushed by reset and by a new start.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      for (int unsigned i = 0; i < DUT_LATENCY; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= (state_q == RUN);
      for (int unsigned i = 1; i < DUT_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Index and expected word travel alongside their token.
  always_ff @(posedge clk) begin
    pidx_q[0] <= idx_q;
    pexp_q[0] <= ram_exp;
    for (int unsigned i = 1; i < DUT_LATENCY; i++) begin
      pidx_q[i] <= pidx_q[i-1];
      pexp_q[i] <= pexp_q[i-1];
    end
  end

  assign cmp_valid = vld_q[DUT_LATENCY-1];
  assign cmp_idx   = pidx_q[DUT_LATENCY-1];
  assign cmp_exp   = pexp_q[DUT_LATENCY-1];

  // Signed difference one bit wider than the operands, then magnitude.
  always_comb begin
    diff     = $signed({bus.dut_out[OUT_W-1], bus.dut_out}) - $signed({cmp_exp[OUT_W-1], cmp_exp});
    mag      = diff[OUT_W] ? $unsigned(-diff) : $unsigned(diff);
    mismatch = cmp_valid && (CW'(mag) > TOL_U);
  end

  // Result flags: cleared per run, updated the cycle after each compare.
  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      err_q   <= '0;
      fail_q  <= 1'b0;
      first_q <= '1;
    end else if (mismatch) begin
      err_q  <= sat_inc(err_q);
      fail_q <= 1'b1;
      if (first_q == '1) first_q <= {1'b0, cmp_idx};
    end
  end

  assign bus.stim_data     = stim_out;
  assign bus.clk_enable    = clk_en;
  assign bus.busy          = busy;
  assign bus.snk_done      = snk_done;
  assign bus.test_failure  = fail_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_stream_stim_checker.sv
// Bench for stream_stim_checker: two instances (strict single-pass and
// TOL=1 loop mode) sharing one table/control bus, each feeding a modelled
// identity DUT with a programmable output offset.
module tb_stream_stim_checker;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LAT   = 4;
  localparam int HOLD  = 2;
  localparam int TOL_A = 0;
  localparam int TOL_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_stim;
  logic [15:0]   load_exp;
  logic [AW:0]   num_samples;
  logic          start;
  logic          stop;
  logic [15:0]   off;

  int total = 0;
  int bad   = 0;

  logic [31:0] stim_tab [DEPTH];
  logic [15:0] exp_tab  [DEPTH];
  logic [32:0] trace [$];

  stream_stim_checker_if #(.DATA_W(32), .OUT_W(16), .ADDR_W(AW)) ifa ();
  stream_stim_checker_if #(.DATA_W(32), .OUT_W(16), .ADDR_W(AW)) ifb ();

  assign ifa.load_we = load_we;     assign ifb.load_we = load_we;
  assign ifa.load_addr = load_addr; assign ifb.load_addr = load_addr;
  assign ifa.load_stim = load_stim; assign ifb.load_stim = load_stim;
  assign ifa.load_exp = load_exp;   assign ifb.load_exp = load_exp;
  assign ifa.num_samples = num_samples; assign ifb.num_samples = num_samples;
  assign ifa.start = start;         assign ifb.start = start;
  assign ifa.stop = stop;           assign ifb.stop = stop;

  stream_stim_checker #(
    .DATA_W(32), .OUT_W(16), .DEPTH(DEPTH), .ADDR_W(AW),
    .DUT_LATENCY(LAT), .TOL(TOL_A), .HOLD_CYCLES(HOLD), .LOOP_EN(0)
  ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

  stream_stim_checker #(
    .DATA_W(32), .OUT_W(16), .DEPTH(DEPTH), .ADDR_W(AW),
    .DUT_LATENCY(LAT), .TOL(TOL_B), .HOLD_CYCLES(HOLD), .LOOP_EN(1)
  ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Modelled DUTs: clock-enabled delay line of LAT stages, output = input + off.
  logic [15:0] pipe_a [LAT];
  logic [15:0] pipe_b [LAT];
  always @(posedge clk) begin
    if (ifa.clk_enable) begin
      pipe_a[0] <= ifa.stim_data[15:0] + off;
      for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end
    if (ifb.clk_enable) begin
      pipe_b[0] <= ifb.stim_data[15:0] + off;
      for (int j = 1; j < LAT; j++) pipe_b[j] <= pipe_b[j-1];
    end
  end
  assign ifa.dut_out = pipe_a[LAT-1];
  assign ifb.dut_out = pipe_b[LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: every presented index is compared once against the tables.
  function automatic void model_run(input int n, input int passes, input int tol,
                                    output int errs, output int first);
    errs  = 0;
    first = -1;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < n; k++) begin
        logic [15:0] dv;
        int d;
        dv = stim_tab[k][15:0] + off;
        d  = int'($signed(dv)) - int'($signed(exp_tab[k]));
        if (d < 0) d = -d;
        if (d > tol) begin
          errs++;
          if (first < 0) first = k;
        end
      end
    end
    if (errs > 65535) errs = 65535;
  endfunction

  task automatic load_word(input int a);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = AW'(a);
    load_stim = stim_tab[a];
    load_exp  = exp_tab[a];
  endtask

  task automatic load_end();
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Pulse start and record (clk_enable, stim_data) each cycle until snk_done.
  task automatic run_capture(input bit use_b, input logic [AW:0] nsamp,
                             input int stop_at, input int poke_at);
    int c;
    bit fin;
    trace.delete();
    num_samples = nsamp;
    @(negedge clk);
    start = 1'b1;
    c   = 0;
    fin = 1'b0;
    while (!fin && c < 200) begin
      @(negedge clk);
      start   = 1'b0;
      load_we = 1'b0;
      if (stop_at > 0) stop = 1'b0;
      if (use_b ? ifb.snk_done : ifa.snk_done) fin = 1'b1;
      else begin
        trace.push_back({use_b ? ifb.clk_enable : ifa.clk_enable,
                         use_b ? ifb.stim_data  : ifa.stim_data});
        c++;
        if (c == stop_at) stop = 1'b1;
        if (c == poke_at) begin
          start     = 1'b1;
          load_we   = 1'b1;
          load_addr = AW'(2);
          load_stim = 32'hDEAD_BEEF;
          load_exp  = 16'h1234;
        end
      end
    end
    check("run_reaches_done", fin, 1);
  endtask

  task automatic check_trace(input string tag, input int n, input int passes);
    logic [32:0] want [$];
    int idx;
    int lim;
    for (int i = 0; i < HOLD; i++) want.push_back(33'd0);
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < n; k++) want.push_back({1'b1, stim_tab[k]});
    for (int i = 0; i < LAT; i++) want.push_back({1'b1, 32'd0});
    check({tag, "_len"}, trace.size(), want.size());
    lim = (trace.size() < want.size()) ? trace.size() : want.size();
    idx = 0;
    while (idx < lim && trace[idx] === want[idx]) idx++;
    if (idx < lim) $display("note: %s cycle %0d got %h want %h", tag, idx, trace[idx], want[idx]);
    check({tag, "_firstdiff"}, idx, lim);
  endtask

  task automatic check_flags(input string tag, input bit use_b, input int n, input int passes);
    int errs;
    int first;
    logic [AW:0] fexp;
    model_run(n, passes, use_b ? TOL_B : TOL_A, errs, first);
    fexp = (first < 0) ? '1 : (AW+1)'(first);
    check({tag, "_done"},  use_b ? ifb.snk_done      : ifa.snk_done, 1);
    check({tag, "_err"},   use_b ? ifb.err_count     : ifa.err_count, errs);
    check({tag, "_fail"},  use_b ? ifb.test_failure  : ifa.test_failure, errs != 0);
    check({tag, "_first"}, use_b ? ifb.first_err_idx : ifa.first_err_idx, fexp);
  endtask

  initial begin
    int passes;
    logic en_seen;
    reset = 1'b1; start = 1'b0; stop = 1'b1; load_we = 1'b0;
    load_addr = '0; load_stim = '0; load_exp = '0; num_samples = '0; off = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.snk_done, 0);
    check("rst_clken", ifa.clk_enable, 0);
    check("rst_stim", ifa.stim_data, 0);
    check("rst_fail", ifa.test_failure, 0);
    check("rst_err", ifa.err_count, 0);
    check("rst_first", ifa.first_err_idx, 5'h1F);
    reset = 1'b0;

    for (int k = 0; k < DEPTH; k++) begin
      stim_tab[k] = $urandom;
      exp_tab[k]  = stim_tab[k][15:0];
      load_word(k);
    end
    load_end();

    // Clean single pass of 8.
    run_capture(0, 5'd8, 0, 0);
    check_trace("pass8", 8, 1);
    check_flags("t1a", 0, 8, 1);
    check_flags("t1b", 1, 8, 1);

    // Two corrupted expected entries.
    exp_tab[3] = 16'd99;
    exp_tab[5] = 16'hFFFF;
    load_word(3);
    load_word(5);
    load_end();
    run_capture(0, 5'd8, 0, 0);
    check_flags("t2a", 0, 8, 1);
    check_flags("t2b", 1, 8, 1);

    // Restore, then offset DUT output by +1 and +2.
    exp_tab[3] = stim_tab[3][15:0];
    exp_tab[5] = stim_tab[5][15:0];
    load_word(3);
    load_word(5);
    load_end();
    off = 16'd1;
    run_capture(0, 5'd8, 0, 0);
    check_flags("t3a_off1", 0, 8, 1);
    check_flags("t3b_off1", 1, 8, 1);
    off = 16'd2;
    run_capture(0, 5'd8, 0, 0);
    check_flags("t3a_off2", 0, 8, 1);
    check_flags("t3b_off2", 1, 8, 1);

    // Loop mode, N=4, stop pulsed in the first cycle of pass 3.
    off  = 16'd0;
    stop = 1'b0;
    run_capture(1, 5'd4, 11, 0);
    passes = (11 - 1 - HOLD) / 4 + 1;
    check_trace("loop", 4, passes);
    check_flags("t4b", 1, 4, passes);
    check_flags("t4a", 0, 4, 1);
    stop = 1'b1;

    // num_samples above DEPTH clamps to DEPTH.
    run_capture(0, 5'd31, 0, 0);
    check_trace("clamp", DEPTH, 1);
    check_flags("t5a", 0, DEPTH, 1);

    // start and load_we during RUN are ignored.
    run_capture(0, 5'd8, 0, 5);
    check_trace("poke", 8, 1);
    check_flags("t6a", 0, 8, 1);
    run_capture(0, 5'd8, 0, 0);
    check_flags("t6a_rerun", 0, 8, 1);

    // Reset in the 5th RUN cycle of a run that would mismatch everywhere.
    off = 16'd5;
    num_samples = 5'd8;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", ifa.busy, 1);
    check("mid_stim", ifa.stim_data, stim_tab[4]);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_busy", ifa.busy, 0);
    check("mrst_clken", ifa.clk_enable, 0);
    check("mrst_stim", ifa.stim_data, 0);
    check("mrst_err", ifa.err_count, 0);
    check("mrst_first", ifa.first_err_idx, 5'h1F);
    reset = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("flush_err", ifa.err_count, 0);
    check("flush_fail", ifa.test_failure, 0);

    // N=0: straight to DONE, clock enable never raised.
    off = 16'd0;
    num_samples = '0;
    @(negedge clk); start = 1'b1;
    en_seen = ifa.clk_enable;
    @(negedge clk); start = 1'b0;
    check("n0_done", ifa.snk_done, 1);
    check("n0_busy", ifa.busy, 0);
    check("n0_fail", ifa.test_failure, 0);
    check("n0_first", ifa.first_err_idx, 5'h1F);
    repeat (4) begin
      en_seen = en_seen | ifa.clk_enable;
      @(negedge clk);
    end
    check("n0_clken", en_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_stim_checker.md
Name: stream_stim_checker

Overview:
- Synthesizable, parametrised successor to our file-driven float stimulus bench.
- Plays a preloaded sample table into a DUT and gates the DUT's clk_enable.
- Compares the DUT output, after a fixed pipeline latency, against a preloaded expected table within a tolerance.
- Raises done/failure flags, so on-chip and simulation regressions share one harness in front of FPGA_Top_Level-style designs.

Parameters:
- DATA_W, 32: stimulus word width (sfix_32_En28 after conversion).
- OUT_W, 16: DUT output and expected word width, signed.
- DEPTH, 1024: table depth; power of two.
- ADDR_W, $clog2(DEPTH): table address width.
- DUT_LATENCY, 4: cycles from an enabled stimulus word to its DUT output; must be ≥1.
- TOL, 0: maximum allowed |dut_out − expected|, unsigned.
- HOLD_CYCLES, 2: cycles clk_enable is held low after start, before the first sample.
- LOOP_EN, 0: 1 = wrap to index 0 after the last sample until stop.

Ports:
- clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- load_we, in, 1: write strobe for both tables; ignored while busy.
- load_addr, in, ADDR_W: table write address.
- load_stim, in, DATA_W: stimulus word to write.
- load_exp, in, OUT_W: expected word to write.
- num_samples, in, ADDR_W+1: samples per pass; sampled on start; values >DEPTH are clamped to DEPTH.
- start, in, 1: single-cycle pulse; ignored unless in IDLE or DONE.
- stop, in, 1: ends loop mode at the next pass boundary; ignored when LOOP_EN=0.
- stim_data, out, DATA_W: stimulus to the DUT.
- clk_enable, out, 1: DUT clock enable.
- dut_out, in, OUT_W: DUT result.
- busy, out, 1: high in HOLD, RUN, DRAIN.
- snk_done, out, 1: high in DONE.
- test_failure, out, 1: sticky; set on any mismatch in the current run.
- err_count, out, 16: mismatch count; saturates at 16'hFFFF.
- first_err_idx, out, ADDR_W+1: sample index of the first mismatch; all-ones if none.

Behaviour:
- Reset (sync, active-high): state=IDLE; stim_data=0; clk_enable=0; busy=0; snk_done=0; test_failure=0; err_count=0; first_err_idx=all-ones. Table contents are not cleared.
- Reset mid-run aborts immediately to IDLE with the values above. The compare pipeline is flushed and no late compares happen.
- FSM states: IDLE, HOLD, RUN, DRAIN, DONE.
- IDLE/DONE --start--> HOLD. On this transition err_count, test_failure and first_err_idx are cleared and num_samples is latched as N.
- If N=0, start goes straight to DONE with test_failure=0.
- HOLD: counts HOLD_CYCLES cycles with clk_enable=0, then goes to RUN.
- RUN: the table is read synchronously (1-cycle read).
  - stim_data=stim[k] and clk_enable=1 in the same cycle, for k=0..N−1, with no gaps.
  - A compare-valid token for index k enters a DUT_LATENCY-deep shift register in that cycle.
- End of pass, LOOP_EN=0: after k=N−1 presents, go to DRAIN.
- End of pass, LOOP_EN=1: k wraps to 0 with no gap. A stop seen during the pass, held until the boundary, goes to DRAIN after k=N−1.
- DRAIN: clk_enable stays 1 and stim_data=0 for exactly DUT_LATENCY cycles so the DUT flushes; then DONE.
- DONE: clk_enable=0, snk_done=1. Stays until start or reset.
- Compare: when a token for index k exits the shift register, compute the signed difference dut_out − exp[k] at OUT_W+1 bits and take its absolute value.
  - If the absolute value exceeds TOL: err_count++ (saturating); test_failure=1.
  - first_err_idx takes k only if it is still all-ones.
- Flag updates are registered and visible the cycle after the compare. The last compare's update is visible no later than the cycle snk_done rises.
- start coincident with reset: reset wins. stop outside RUN: ignored.

Decomposition:
- Package stream_stim_pkg holds the FSM state enum and the saturating-increment helper function.
- One sub-module, stim_exp_ram: dual-table, single-clock, one write port, one sync read port. Its read address is driven by the FSM and the compare index is delayed from the same counter.

Test Plan:
- Load 8 stim words and exp={0..7}, with the DUT modelled as an identity delay of 4 and N=8. Pulse start → clk_enable low 2 cycles then high 12 cycles; snk_done=1; err_count=0; test_failure=0; first_err_idx=all-ones.
- Same run with exp[3]=99 and exp[5]=−1 → err_count=2, first_err_idx=3, test_failure=1.
- TOL=1 with DUT outputs offset by +1 from exp → pass. Offset of +2 → err_count=8.
- LOOP_EN=1, N=4, stop asserted during pass 3 → 12 stimulus words presented, indices 0,1,2,3 repeating, then 4 drain cycles, then snk_done.
- Reset asserted in the 5th RUN cycle → next cycle all outputs at reset values; a subsequent start with N=0 → DONE within 1 cycle, clk_enable never high.
- start pulsed during RUN and load_we during RUN → no restart, tables unchanged (verify by a re-run with the original exp giving err_count=0).
